// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus/address widths and the bus-source select
// enumeration used by the top-level bus mux and CPULogic.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [3:0] {
    SRC_R0  = 4'd0,
    SRC_R1  = 4'd1,
    SRC_R2  = 4'd2,
    SRC_R3  = 4'd3,
    SRC_IR  = 4'd4,
    SRC_ALU = 4'd5,
    SRC_RAM = 4'd6,
    SRC_PC  = 4'd7,
    SRC_IN  = 4'd8
  } bus_src_e;

endpackage

// File: rtl/sys_in_fifo_mem.sv
// DEPTH x WIDTH storage for the SYS_IN FIFO: synchronous write, asynchronous
// read, contents are not reset.
module sys_in_fifo_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sys_in_port.sv
// SYS_IN input port: full-rate valid/ready producer side, SLOW_CLOCK_STRB
// qualified CPU pop side, circular FIFO in between. Optional ERR output via
// the SYS_IN_ERR_EN macro.
module sys_in_port
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SLOW_CLOCK_STRB,
  input  logic [WIDTH-1:0]       SYS_IN,
  input  logic                   SYS_IN_VALID,
  output logic                   SYS_IN_READY,
  input  logic                   IN_RD,
  output logic [WIDTH-1:0]       BUS_OUT,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT
`ifdef SYS_IN_ERR_EN
  ,
  output logic                   ERR
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  assign SYS_IN_READY = (count != FULL_CNT);
  assign EMPTY        = (count == '0);
  assign COUNT        = count;
  assign push         = SYS_IN_VALID && SYS_IN_READY;
  assign pop          = IN_RD && SLOW_CLOCK_STRB && !EMPTY;

  sys_in_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk  (CLK),
    .we   (push && !RST),
    .waddr(wr_ptr),
    .wdata(SYS_IN),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_comb begin
    BUS_OUT = '0;
    if (!EMPTY) BUS_OUT = head;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYS_IN_ERR_EN
  logic [7:0] stall_cnt;
  logic       stalled;

  assign stalled = SYS_IN_VALID && !SYS_IN_READY;

  // stall_cnt==255 on a still-stalled edge means the 256th consecutive cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      ERR       <= 1'b0;
    end else begin
      if (!stalled)              stall_cnt <= '0;
      else if (stall_cnt != '1)  stall_cnt <= stall_cnt + 8'd1;
      if ((IN_RD && SLOW_CLOCK_STRB && EMPTY) || (stalled && stall_cnt == '1))
        ERR <= 1'b1;
    end
  end
`endif

endmodule
